// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for the single-port on-chip SRAM.
// Port A always wins; port B commands fill the cycles port A leaves idle.
module sram_port_arbiter #(
  parameter int AW           = 32,
  parameter int CW           = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_cs_n,
  input  logic          a_wr_n,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_din,
  input  logic [3:0]    a_ben,
  output logic [31:0]   a_dout,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  input  logic [3:0]    b_ben,
  output logic          b_gnt,
  output logic          b_busy,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  input  logic          starve_clr,
  output logic          starve_flag,
  output logic          ramcs_n,
  output logic          ramwr_n,
  output logic [AW-1:0] ramaddr,
  output logic [31:0]   ramdin,
  output logic [3:0]    ramben,
  input  logic [31:0]   ramdout
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    ben;
  } cmd_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] LIM_M1  = CW'(STARVE_LIMIT - 1);

  state_t        state;
  cmd_t          hold;
  logic [CW-1:0] wait_cnt;
  logic          pend;
  logic          issue;
  logic          blocked;

  assign pend    = (state == PEND);
  assign issue   = pend & a_cs_n;
  assign blocked = pend & ~a_cs_n;

  assign b_gnt   = b_req & (~pend | issue);
  assign b_busy  = pend;
  assign a_dout  = ramdout;
  assign b_rdata = ramdout;

  // Port A sees the SRAM with zero added latency.
  always_comb begin
    ramcs_n = 1'b1;
    ramwr_n = 1'b1;
    ramaddr = a_addr;
    ramdin  = a_din;
    ramben  = a_ben;
    if (!a_cs_n) begin
      ramcs_n = 1'b0;
      ramwr_n = a_wr_n;
    end else if (pend) begin
      ramcs_n = 1'b0;
      ramwr_n = ~hold.wr;
      ramaddr = hold.addr;
      ramdin  = hold.wdata;
      ramben  = hold.ben;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      b_rvalid    <= 1'b0;
      wait_cnt    <= '0;
      starve_flag <= 1'b0;
    end else begin
      b_rvalid <= issue & ~hold.wr;

      if (b_gnt) begin
        hold  <= '{wr: b_wr, addr: b_addr,
                   wdata: b_wdata, ben: b_ben};
        state <= PEND;
      end else if (issue) begin
        state <= IDLE;
      end

      if (!blocked) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CW'(1);
      end

      // A fresh starvation event beats a simultaneous clear.
      if (blocked && wait_cnt == LIM_M1) begin
        starve_flag <= 1'b1;
      end else if (starve_clr) begin
        starve_flag <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares the single-port, zero-wait-state on-chip SRAM between two requesters. Port A is the AHB SRAM controller's inner interface and has absolute priority, because it cannot be stalled. Port B is a DMA/debug-style requester with a one-entry command holding register; its commands fill SRAM cycles that port A leaves free. A starvation monitor reports when port B has waited too long.

Parameters:
AW, 32, SRAM address width for both ports and the SRAM side
CW, 4, width of the starvation wait counter
STARVE_LIMIT, 15, blocked-cycle count that sets starve_flag (must be ≤ 2^CW-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_cs_n  input  1  port A chip select, active low
a_wr_n  input  1  port A write strobe, active low
a_addr  input  AW  port A address
a_din  input  32  port A write data
a_ben  input  4  port A byte enables
a_dout  output  32  port A read data (= ramdout)
b_req  input  1  port B command request
b_wr  input  1  port B command is a write (1) or a read (0)
b_addr  input  AW  port B address
b_wdata  input  32  port B write data
b_ben  input  4  port B byte enables
b_gnt  output  1  command accepted this cycle
b_busy  output  1  holding register occupied
b_rvalid  output  1  port B read data valid
b_rdata  output  32  port B read data (= ramdout)
starve_clr  input  1  clears starve_flag
starve_flag  output  1  sticky starvation indicator
ramcs_n  output  1  SRAM chip select, active low
ramwr_n  output  1  SRAM write strobe, active low
ramaddr  output  AW  SRAM address
ramdin  output  32  SRAM write data
ramben  output  4  SRAM byte enables
ramdout  input  32  SRAM read data, valid the cycle after a read select

Behaviour:
- Reset values: pend=0, holding registers 0, b_rvalid=0, wait counter 0, starve_flag=0. With no access pending: ramcs_n=1, ramwr_n=1, b_gnt=0, b_busy=0.
- State: pend (IDLE = 0, PEND = 1).
- SRAM mux is purely combinational, with no added latency.
  - a_cs_n=0: SRAM driven from port A (cs, wr, addr, din, ben).
  - Else pend=1 (issue cycle): ramcs_n=0, ramwr_n=~hold_wr, with addr/wdata/ben taken from the holding register.
  - Else: ramcs_n=1, ramwr_n=1, addr/din/ben follow port A inputs.
- issue = pend & a_cs_n.
- b_gnt = b_req & (~pend | issue), combinational.
  - On b_gnt the holding register loads b_wr/b_addr/b_wdata/b_ben and pend<=1.
  - Otherwise, on issue, pend<=0.
  - A new command is accepted in the same cycle the previous one issues, giving one command per cycle back-to-back.
- b_busy = pend. b_req with b_gnt=0 is not accepted; the requester must hold its inputs stable until b_gnt.
- b_rvalid is registered: it is asserted for exactly one cycle, in the cycle after a read issue. b_rdata is valid only while b_rvalid=1.
- a_dout is always ramdout. Port A's read data phase is never disturbed, because a port B issue changes ramdout only one cycle later.
- Wait counter:
  - Clears when pend=0 or on issue.
  - Increments, saturating at 2^CW-1, in each cycle with pend=1 & a_cs_n=0.
  - When the counter value equals STARVE_LIMIT-1 and the cycle is blocked, starve_flag<=1 (the set fires on the STARVE_LIMIT-th blocked cycle).
- starve_flag clears on starve_clr. If the set and starve_clr coincide, the set wins.
- Port B may wait indefinitely; the arbiter never stalls port A.
- Reset mid-operation drops any pending command with no SRAM access and no b_rvalid. Reset asserted in the cycle after a read issue suppresses b_rvalid.
- Simultaneous a_cs_n=0 and b_req with pend=0: the command is latched (b_gnt=1), port A is served, and port B issues at the first free cycle.

Test Plan:
1. Port A idle; b_req read at cycle 0, b_addr=0x40 → b_gnt=1 at cycle 0; ramcs_n=0, ramwr_n=1, ramaddr=0x40 at cycle 1; b_rvalid=1 at cycle 2 with b_rdata=ramdout.
2. Port A write active at cycles 0–3; b_req write at cycle 0, data 0xA5A5_5A5A, ben 4'b1111 → SRAM shows port A at cycles 0–3, port B write at cycle 4; b_busy=1 at cycles 1–4, 0 at cycle 5.
3. Port A idle; b_req held for 4 commands → b_gnt=1 every cycle; 4 consecutive SRAM accesses at cycles 1–4; b_busy stays 1 through cycle 4.
4. Port B pending while port A is busy for 20 cycles → starve_flag rises after the 15th blocked cycle and stays 1. starve_clr pulsed with no new starvation → 0. starve_clr coinciding with a set → stays 1.
5. Read pending, rst_n pulsed low mid-PEND → pend=0, b_rvalid=0, ramcs_n=1 during reset; after release no port B access occurs.
6. Port A read at cycle 0 and port B read issued at cycle 1 → a_dout correct at cycle 1, b_rdata correct at cycle 2, and no cross-corruption between the two ports.
